// File: rtl/alu_datapath_pkg.sv
// -----------------------------------------------------------------------------
// alu_datapath_pkg
// Shared definitions for the multi-cycle ALU datapath.
//   - ALU function codes (op[2:0]); op[3] is the immediate-select bit.
//   - Control FSM state encoding.
//   - Bit positions inside the 4-bit {V,C,N,Z} flag vector.
// Optional feature macro: ALU_MUL_EN (enables function code 7 as MUL).
// -----------------------------------------------------------------------------
package alu_datapath_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_NOT = 3'd5;
   localparam logic [2:0] OP_SHL = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2,
      ST_WB     = 2'd3
   } state_t;

endpackage

// File: rtl/alu_datapath_alu.sv
// -----------------------------------------------------------------------------
// alu_datapath_alu
// Purely combinational ALU: (A, B, function) -> (result, flags, valid).
// Ports:
//   i_a, i_b : operands (unsigned bit vectors, WIDTH bits)
//   i_op     : 3-bit function code
//   o_res    : result, truncated to WIDTH
//   o_flags  : {V,C,N,Z}
//   o_valid  : low for an unimplemented function code
// Optional feature macro: ALU_MUL_EN (code 7 = MUL; otherwise code 7 invalid
// and no multiplier is built).
// -----------------------------------------------------------------------------
module alu_datapath_alu
   import alu_datapath_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [2:0]       i_op,
   output logic [WIDTH-1:0] o_res,
   output logic [3:0]       o_flags,
   output logic             o_valid
);

   localparam int SH_W = $clog2(WIDTH);

   logic        [WIDTH:0]   w_sum;
   logic        [WIDTH:0]   w_diff;
   logic signed [WIDTH-1:0] w_sa;
   logic signed [WIDTH-1:0] w_sb;
   logic                    w_c;
   logic                    w_v;

   // Extra top bit catches the ADD carry-out / SUB borrow (A < B unsigned).
   assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
   assign w_diff = {1'b0, i_a} - {1'b0, i_b};
   assign w_sa   = $signed(i_a);
   assign w_sb   = $signed(i_b);

   always_comb begin
      o_res   = '0;
      o_valid = 1'b1;
      w_c     = 1'b0;
      w_v     = 1'b0;
      case (i_op)
         OP_ADD: begin
            o_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            // Overflow: same-sign operands giving an opposite-sign result.
            w_v   = (w_sa[WIDTH-1] == w_sb[WIDTH-1]) && (o_res[WIDTH-1] != w_sa[WIDTH-1]);
         end
         OP_SUB: begin
            o_res = w_diff[WIDTH-1:0];
            w_c   = w_diff[WIDTH];
            // Overflow: differing-sign operands, result sign differs from A.
            w_v   = (w_sa[WIDTH-1] != w_sb[WIDTH-1]) && (o_res[WIDTH-1] != w_sa[WIDTH-1]);
         end
         OP_AND: o_res = i_a & i_b;
         OP_OR:  o_res = i_a | i_b;
         OP_XOR: o_res = i_a ^ i_b;
         OP_NOT: o_res = ~i_a;
         OP_SHL: o_res = i_a << i_b[SH_W-1:0];
         OP_MUL: begin
`ifdef ALU_MUL_EN
            o_res = i_a * i_b;
`else
            o_valid = 1'b0;
`endif
         end
         default: o_valid = 1'b0;
      endcase
      o_flags         = '0;
      o_flags[FLAG_Z] = (o_res == '0);
      o_flags[FLAG_N] = o_res[WIDTH-1];
      o_flags[FLAG_C] = w_c;
      o_flags[FLAG_V] = w_v;
   end

endmodule

// File: rtl/alu_datapath_core.sv
// -----------------------------------------------------------------------------
// alu_datapath_core
// Multi-cycle ALU datapath: instruction latch/decoder, register file,
// immediate mux, ALU (alu_datapath_alu), flag register and control FSM.
// One instruction per START/RDY handshake, IDLE -> DECODE -> EXEC -> WB.
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   START, Instr        instruction valid / {op[3:0], rA, rB/imm, rC}
//   RDY                 high in IDLE
//   DONE                one-cycle pulse in WB
//   FLAGS               registered {V,C,N,Z}
//   ERR                 sticky invalid-opcode flag, cleared on accepted START
//   LD_EN/ADDR/DATA     register-file load port (IDLE only)
//   DBG_ADDR/DBG_DATA   combinational register-file read port
// Optional feature macro: ALU_MUL_EN (function code 7 = MUL).
// -----------------------------------------------------------------------------
module alu_datapath_core
   import alu_datapath_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int RADDR_W = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     START,
   input  logic [4+3*RADDR_W-1:0]   Instr,
   output logic                     RDY,
   output logic                     DONE,
   output logic [3:0]               FLAGS,
   output logic                     ERR,
   input  logic                     LD_EN,
   input  logic [RADDR_W-1:0]       LD_ADDR,
   input  logic [WIDTH-1:0]         LD_DATA,
   input  logic [RADDR_W-1:0]       DBG_ADDR,
   output logic [WIDTH-1:0]         DBG_DATA
);

   localparam int NREGS   = 2**RADDR_W;
   localparam int INSTR_W = 4 + 3*RADDR_W;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [INSTR_W-1:0]   r_instr;
   logic [WIDTH-1:0]     r_regs [NREGS];
   logic [WIDTH-1:0]     r_opa;
   logic [WIDTH-1:0]     r_opb;
   logic [WIDTH-1:0]     r_res;
   logic                 r_wr_en;
   logic [3:0]           r_flags;
   logic                 r_err;

   logic [3:0]           w_op;
   logic [RADDR_W-1:0]   w_ra;
   logic [RADDR_W-1:0]   w_rb;
   logic [RADDR_W-1:0]   w_rc;
   logic [WIDTH-1:0]     w_imm;
   logic [WIDTH-1:0]     w_alu_res;
   logic [3:0]           w_alu_flags;
   logic                 w_alu_valid;
   logic                 w_accept;
   logic                 w_load;

   assign w_op  = r_instr[INSTR_W-1 -: 4];
   assign w_ra  = r_instr[3*RADDR_W-1 -: RADDR_W];
   assign w_rb  = r_instr[2*RADDR_W-1 -: RADDR_W];
   assign w_rc  = r_instr[RADDR_W-1:0];
   assign w_imm = {{(WIDTH-RADDR_W){1'b0}}, w_rb};

   assign w_accept = (r_state == ST_IDLE) && START;
   assign w_load   = (r_state == ST_IDLE) && LD_EN;

   assign RDY      = (r_state == ST_IDLE);
   assign DONE     = (r_state == ST_WB);
   assign FLAGS    = r_flags;
   assign ERR      = r_err;
   assign DBG_DATA = r_regs[DBG_ADDR];

   // Control FSM
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (START) w_state_nxt = ST_DECODE;
         ST_DECODE: w_state_nxt = ST_EXEC;
         ST_EXEC:   w_state_nxt = ST_WB;
         ST_WB:     w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Stage 0 (IDLE -> DECODE): latch the instruction word
   always_ff @(posedge CLK) begin
      if (w_accept) r_instr <= Instr;
   end

   // Stage 1 (DECODE -> EXEC): operand fetch with immediate select on op[3]
   always_ff @(posedge CLK) begin
      if (r_state == ST_DECODE) begin
         r_opa <= r_regs[w_ra];
         r_opb <= w_op[3] ? w_imm : r_regs[w_rb];
      end
   end

   alu_datapath_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .i_a     (r_opa),
      .i_b     (r_opb),
      .i_op    (w_op[2:0]),
      .o_res   (w_alu_res),
      .o_flags (w_alu_flags),
      .o_valid (w_alu_valid)
   );

   // Stage 2 (EXEC -> WB): register result
   always_ff @(posedge CLK) begin
      if (r_state == ST_EXEC) r_res <= w_alu_res;
   end

   // Architectural state: register file, flags, error, write-back enable.
   // Loads and write-back never collide since loads are honoured in IDLE only.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
         r_flags <= '0;
         r_err   <= 1'b0;
         r_wr_en <= 1'b0;
      end else begin
         if (w_load) r_regs[LD_ADDR] <= LD_DATA;
         if (w_accept) r_err <= 1'b0;
         if (r_state == ST_EXEC) begin
            r_wr_en <= w_alu_valid;
            if (w_alu_valid) r_flags <= w_alu_flags;
            else             r_err   <= 1'b1;
         end
         // Stage 3 (WB -> IDLE): write-back
         if ((r_state == ST_WB) && r_wr_en) r_regs[w_rc] <= r_res;
      end
   end

endmodule
